// File: rtl/tmds_channel_decoder.sv
// Receive-side TMDS channel: hunts for control tokens to find the symbol boundary in the
// raw deserializer words, then decodes each aligned symbol into pixel data or a control value.
module tmds_channel_decoder #(
    parameter int LOCK_COUNT    = 8,
    parameter int SEARCH_CYCLES = 2048,
    parameter int LOSS_CYCLES   = 4096
) (
    input  logic       i_pix_clk,
    input  logic       i_rst,
    input  logic [9:0] i_word,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    localparam int RUN_W    = $clog2(LOCK_COUNT + 1);
    localparam int SEARCH_W = $clog2(SEARCH_CYCLES + 1);
    localparam int LOSS_W   = $clog2(LOSS_CYCLES + 1);

    localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(LOCK_COUNT - 1);
    localparam logic [RUN_W-1:0]    RUN_MAX     = RUN_W'(LOCK_COUNT);
    localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(SEARCH_CYCLES - 1);
    localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_CYCLES - 1);
    localparam logic [LOSS_W-1:0]   LOSS_MAX    = LOSS_W'(LOSS_CYCLES);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t              state;
    state_t              state_next;
    logic [9:0]          prev_word;
    logic [9:0]          aw;
    logic [9:0]          aw_next;
    logic [19:0]         hist;
    logic [3:0]          offset;
    logic [RUN_W-1:0]    run_cnt;
    logic [SEARCH_W-1:0] search_cnt;
    logic [LOSS_W-1:0]   loss_cnt;
    logic                is_ctrl;
    logic [1:0]          tok;
    logic [7:0]          q;
    logic [7:0]          d;
    logic                lock_hit;
    logic                loss_hit;
    logic [7:0]          data_next;
    logic [1:0]          ctrl_next;
    logic                de_next;

    assign hist     = {i_word, prev_word};
    assign lock_hit = (state == SEARCH) && is_ctrl && (run_cnt == RUN_LAST);
    assign loss_hit = (state == LOCKED) && !is_ctrl && (loss_cnt == LOSS_LAST);
    assign o_locked = (state == LOCKED);
    assign o_offset = offset;

    // Barrel select of the 10-bit window starting at the current bit-slip offset.
    always_comb begin
        aw_next = hist[9:0];
        for (int k = 1; k < 10; k++) begin
            if (offset == 4'(k)) begin
                aw_next = hist[k +: 10];
            end
        end
    end

    always_comb begin
        is_ctrl = 1'b1;
        tok     = 2'b00;
        case (aw)
            10'h354: tok = 2'b00;
            10'h0AB: tok = 2'b01;
            10'h154: tok = 2'b10;
            10'h2AB: tok = 2'b11;
            default: is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        q    = aw[9] ? ~aw[7:0] : aw[7:0];
        d    = 8'h00;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = aw[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH:  if (lock_hit) state_next = LOCKED;
            LOCKED:  if (loss_hit) state_next = SEARCH;
            default: state_next = SEARCH;
        endcase
    end

    // Outputs follow the state being entered, so forcing starts on the same edge lock changes.
    always_comb begin
        data_next = 8'h00;
        ctrl_next = 2'b00;
        de_next   = 1'b0;
        if (state_next == LOCKED) begin
            if (is_ctrl) begin
                ctrl_next = tok;
            end else begin
                de_next   = 1'b1;
                data_next = d;
                ctrl_next = o_ctrl;
            end
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            prev_word <= 10'h000;
            aw        <= 10'h000;
            o_data    <= 8'h00;
            o_ctrl    <= 2'b00;
            o_de      <= 1'b0;
        end else begin
            prev_word <= i_word;
            aw        <= aw_next;
            o_data    <= data_next;
            o_ctrl    <= ctrl_next;
            o_de      <= de_next;
        end
    end

    // Lock beats a simultaneous search timeout; offset only moves while searching.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            offset     <= 4'd0;
            run_cnt    <= '0;
            search_cnt <= '0;
            loss_cnt   <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (lock_hit) begin
                        run_cnt    <= RUN_MAX;
                        search_cnt <= '0;
                        loss_cnt   <= '0;
                    end else if (search_cnt == SEARCH_LAST) begin
                        offset     <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                        run_cnt    <= '0;
                        search_cnt <= '0;
                    end else begin
                        if (!is_ctrl) begin
                            run_cnt <= '0;
                        end else if (run_cnt != RUN_MAX) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                        search_cnt <= search_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (is_ctrl) begin
                        loss_cnt <= '0;
                    end else if (loss_cnt != LOSS_MAX) begin
                        loss_cnt <= loss_cnt + 1'b1;
                    end
                    if (loss_hit) begin
                        run_cnt    <= '0;
                        search_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: serialises symbol streams at a chosen bit
// boundary and compares the decoded outputs with a symbol-level reference model.
module tb_tmds_channel_decoder;

    localparam int LOCK_COUNT    = 8;
    localparam int SEARCH_CYCLES = 2048;
    localparam int LOSS_CYCLES   = 4096;

    typedef struct {
        logic [9:0] sym;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de;
    } vec_t;

    logic       i_pix_clk = 1'b0;
    logic       i_rst;
    logic [9:0] i_word;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_de;
    logic       o_locked;
    logic [3:0] o_offset;

    int         checks = 0;
    int         errors = 0;
    int         cur_k = 0;
    logic [9:0] last_sym = 10'h000;
    logic [9:0] sent [3];
    bit         model_on = 0;
    bit         model_locked = 0;
    int         nontok = 0;
    logic [1:0] model_ctrl = 2'b00;
    bit         early_lock;
    bit         got_lock;
    vec_t       vecs [9];
    logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    tmds_channel_decoder #(
        .LOCK_COUNT(LOCK_COUNT),
        .SEARCH_CYCLES(SEARCH_CYCLES),
        .LOSS_CYCLES(LOSS_CYCLES)
    ) dut (
        .i_pix_clk(i_pix_clk),
        .i_rst(i_rst),
        .i_word(i_word),
        .o_data(o_data),
        .o_ctrl(o_ctrl),
        .o_de(o_de),
        .o_locked(o_locked),
        .o_offset(o_offset)
    );

    always #5 i_pix_clk = ~i_pix_clk;

    // Token position in the table is its control value.
    function automatic void tok_lookup(input logic [9:0] s, output logic found, output logic [1:0] val);
        found = 1'b0;
        val   = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (s == tok_tab[i]) begin
                found = 1'b1;
                val   = 2'(i);
            end
        end
    endfunction

    // Inverse of the transition-minimising encode: undo the optional inversion, then
    // adjacent-bit XOR, complemented on bits 7:1 when the XNOR variant was used.
    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] qq;
        logic [7:0] r;
        qq = s[9] ? ~s[7:0] : s[7:0];
        r  = qq ^ {qq[6:0], 1'b0};
        if (!s[8]) r = r ^ 8'hFE;
        return r;
    endfunction

    function automatic logic [9:0] randData();
        logic [9:0] s;
        logic       f;
        logic [1:0] v;
        s = 10'h000;
        f = 1'b1;
        while (f) begin
            s = 10'($urandom_range(0, 1023));
            tok_lookup(s, f, v);
        end
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] e_data, input logic [1:0] e_ctrl,
                               input logic e_de, input logic e_locked, input logic [3:0] e_offset);
        checks++;
        if ({o_data, o_ctrl, o_de, o_locked, o_offset} !== {e_data, e_ctrl, e_de, e_locked, e_offset}) begin
            errors++;
            $display("[TB] FAIL %s: got data=%h ctrl=%b de=%b locked=%b offset=%0d, expected data=%h ctrl=%b de=%b locked=%b offset=%0d",
                     name, o_data, o_ctrl, o_de, o_locked, o_offset, e_data, e_ctrl, e_de, e_locked, e_offset);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic applyRaw(input logic [9:0] w);
        i_word = w;
        @(posedge i_pix_clk);
        #1;
    endtask

    // Symbols are laid into the bit stream so that each one starts cur_k bits into a word.
    // A symbol sent on edge j reaches the outputs after edge j+2.
    task automatic applyStimulus(input logic [9:0] sym);
        logic [19:0] pair;
        logic [9:0]  s;
        logic        tf;
        logic [1:0]  tv;
        pair     = {sym, last_sym} >> (10 - cur_k);
        last_sym = sym;
        sent[2]  = sent[1];
        sent[1]  = sent[0];
        sent[0]  = sym;
        applyRaw(pair[9:0]);
        if (model_on) begin
            s = sent[2];
            tok_lookup(s, tf, tv);
            if (model_locked) begin
                if (tf) nontok = 0;
                else nontok++;
                if (nontok >= LOSS_CYCLES) model_locked = 0;
            end
            if (!model_locked) begin
                checkOutput("model_unlocked", 8'h00, 2'b00, 1'b0, 1'b0, 4'(cur_k));
            end else if (tf) begin
                model_ctrl = tv;
                checkOutput("model_token", 8'h00, tv, 1'b0, 1'b1, 4'(cur_k));
            end else begin
                checkOutput("model_data", ref_decode(s), model_ctrl, 1'b1, 1'b1, 4'(cur_k));
            end
        end
    endtask

    task automatic applyReset();
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyRaw(10'($urandom_range(0, 1023)));
            checkOutput("reset_hold", 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);
        end
        i_rst    = 1'b0;
        last_sym = 10'h000;
        model_on = 0;
    endtask

    task automatic waitLock(input string name, input int budget, input int exp_offset);
        got_lock = 0;
        for (int t = 0; t < budget; t++) begin
            applyStimulus(10'h354);
            if (o_locked) begin
                got_lock = 1;
                break;
            end
        end
        checkValue(name, int'(got_lock), 1);
        checkValue({name, "_offset"}, int'(o_offset), exp_offset);
    endtask

    task automatic randomLocked(input int n);
        model_on     = 1;
        model_locked = 1;
        nontok       = 0;
        model_ctrl   = 2'b00;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(tok_tab[$urandom_range(0, 3)]);
            else applyStimulus(randData());
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{10'h100, 8'h00, 2'b00, 1'b1};
        vecs[1] = '{10'h3FF, 8'h00, 2'b00, 1'b1};
        vecs[2] = '{10'h1FF, 8'h01, 2'b00, 1'b1};
        // 0x0FF is the XNOR form of all-ones data
        vecs[3] = '{10'h0FF, 8'hFF, 2'b00, 1'b1};
        vecs[4] = '{10'h0AB, 8'h00, 2'b01, 1'b0};
        vecs[5] = '{10'h154, 8'h00, 2'b10, 1'b0};
        vecs[6] = '{10'h2AB, 8'h00, 2'b11, 1'b0};
        vecs[7] = '{10'h1FF, 8'h01, 2'b11, 1'b1};
        vecs[8] = '{10'h354, 8'h00, 2'b00, 1'b0};
        for (int i = 0; i < 3; i++) sent[i] = 10'h000;
        i_rst  = 1'b1;
        i_word = 10'h000;

        applyReset();
        for (int i = 0; i < 5; i++) begin
            applyRaw(10'($urandom_range(0, 1023)));
            checkOutput("idle_after_reset", 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);
        end

        // Token stream with its boundary three bits in: offsets 0..2 never match.
        applyReset();
        cur_k      = 3;
        early_lock = 0;
        for (int n = 1; n <= 3 * SEARCH_CYCLES; n++) begin
            applyStimulus(10'h354);
            if (o_locked) early_lock = 1;
            if (n % SEARCH_CYCLES == SEARCH_CYCLES - 1) checkValue("slip_before", int'(o_offset), n / SEARCH_CYCLES);
            if (n % SEARCH_CYCLES == 0) checkValue("slip_after", int'(o_offset), n / SEARCH_CYCLES);
        end
        checkValue("no_early_lock", int'(early_lock), 0);
        waitLock("lock_at_3", LOCK_COUNT + 2, 3);
        applyStimulus(10'h354);
        applyStimulus(10'h354);
        checkOutput("locked_idle", 8'h00, 2'b00, 1'b0, 1'b1, 4'd3);

        randomLocked(1500);

        for (int i = 0; i < 4; i++) applyStimulus(10'h354);
        for (int i = 0; i < LOSS_CYCLES; i++) applyStimulus(randData());
        applyStimulus(10'h354);
        applyStimulus(10'h354);
        model_on = 0;
        checkValue("loss_dropped", int'(o_locked), 0);
        waitLock("relock_at_3", LOCK_COUNT + 4, 3);

        applyReset();
        cur_k = 0;
        waitLock("lock_at_0", 2 * LOCK_COUNT + 4, 0);
        applyStimulus(10'h354);
        applyStimulus(10'h354);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(i < 9 ? vecs[i].sym : 10'h354);
            if (i >= 2) begin
                checkOutput($sformatf("vec%0d", i - 2), vecs[i-2].data, vecs[i-2].ctrl, vecs[i-2].de, 1'b1, 4'd0);
            end
        end

        randomLocked(1000);
        model_on = 0;

        // Random raw words never hold a token run, so the offset walks and wraps.
        applyReset();
        early_lock = 0;
        for (int n = 1; n <= 11 * SEARCH_CYCLES + 100; n++) begin
            applyRaw(10'($urandom_range(0, 1023)));
            if (o_locked) early_lock = 1;
            if (n % SEARCH_CYCLES == SEARCH_CYCLES - 1) checkValue("walk_before", int'(o_offset), (n / SEARCH_CYCLES) % 10);
            if (n % SEARCH_CYCLES == 0) checkValue("walk_after", int'(o_offset), (n / SEARCH_CYCLES) % 10);
        end
        checkValue("walk_never_locked", int'(early_lock), 0);
        i_rst = 1'b1;
        applyRaw(10'($urandom_range(0, 1023)));
        checkOutput("mid_reset", 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);
        i_rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
